trap_timer_pipe_ctrl: RTL and testbench



---
 rtl/clint_pkg.sv | 67 ++++++
 rtl/clint_mtime.sv | 69 ++++++
 rtl/trap_timer_pipe_ctrl.sv | 83 ++++++++
 tb/tb_trap_timer_pipe_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg
// Shared constants for the machine-timer / pipeline hazard controller:
//   - CLINT base address and the four timer register offsets
//   - full byte addresses of the timer registers
//   - stage-bit indices for the 6-bit stall/flush vectors
//   - the stall/flush patterns produced by the hazard priority encoder
//   - a register-select enum plus an address decoder shared by the timer
package clint_pkg;

    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;

    localparam logic [31:0] OFF_MTIMECMP_LO = 32'h0000_4000;
    localparam logic [31:0] OFF_MTIMECMP_HI = 32'h0000_4004;
    localparam logic [31:0] OFF_MTIME_LO    = 32'h0000_BFF8;
    localparam logic [31:0] OFF_MTIME_HI    = 32'h0000_BFFC;

    localparam logic [31:0] ADDR_MTIMECMP_LO = CLINT_BASE + OFF_MTIMECMP_LO;
    localparam logic [31:0] ADDR_MTIMECMP_HI = CLINT_BASE + OFF_MTIMECMP_HI;
    localparam logic [31:0] ADDR_MTIME_LO    = CLINT_BASE + OFF_MTIME_LO;
    localparam logic [31:0] ADDR_MTIME_HI    = CLINT_BASE + OFF_MTIME_HI;

    // Bit positions inside stall_o / flush_o
    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IF_ID = 1;
    localparam int unsigned STG_ID_EX = 2;
    localparam int unsigned STG_EX_MEM = 3;
    localparam int unsigned STG_MEM_WB = 4;
    localparam int unsigned STG_WB    = 5;

    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] FLUSH_NONE     = 6'b000000;
    localparam logic [5:0] FLUSH_RESET    = 6'b111111;
    localparam logic [5:0] FLUSH_TRAP     = 6'b011110;
    localparam logic [5:0] STALL_TRAP     = 6'b111111;
    localparam logic [5:0] STALL_MEM      = 6'b011111;
    localparam logic [5:0] FLUSH_MEM      = 6'b100000;
    localparam logic [5:0] STALL_MULDIV   = 6'b001111;
    localparam logic [5:0] FLUSH_MULDIV   = 6'b010000;
    localparam logic [5:0] FLUSH_JUMP     = 6'b000110;
    localparam logic [5:0] STALL_LOAD_USE = 6'b000011;
    localparam logic [5:0] FLUSH_LOAD_USE = 6'b000100;
    localparam logic [5:0] STALL_IF       = 6'b000001;
    localparam logic [5:0] FLUSH_IF       = 6'b000010;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } clint_reg_e;

    // Full 32-bit match: anything outside the four words is unmapped.
    function automatic clint_reg_e decode_addr(input logic [31:0] addr);
        clint_reg_e sel;
        sel = REG_NONE;
        case (addr)
            ADDR_MTIMECMP_LO: sel = REG_MTIMECMP_LO;
            ADDR_MTIMECMP_HI: sel = REG_MTIMECMP_HI;
            ADDR_MTIME_LO:    sel = REG_MTIME_LO;
            ADDR_MTIME_HI:    sel = REG_MTIME_HI;
            default:          sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/clint_mtime.sv
// clint_mtime
// 64-bit mtime counter and mtimecmp register with word-wide bus access.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   addr_i, write_valid_i,
//   wdata_i                 - register write port (takes effect next edge)
//   rdata_o                 - combinational read of the addressed word
//   mtime_ge_mtimecmp_o     - level flag, mtime >= mtimecmp (unsigned)
module clint_mtime
    import clint_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic        write_valid_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        mtime_ge_mtimecmp_o
);

    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    clint_reg_e  reg_sel;

    assign reg_sel = decode_addr(addr_i);

    // A write to either mtime half suppresses the increment for the whole
    // 64-bit counter that cycle, so software sees exactly the value written.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (write_valid_i) begin
            case (reg_sel)
                REG_MTIME_LO:    mtime_d = {mtime_q[63:32], wdata_i};
                REG_MTIME_HI:    mtime_d = {wdata_i, mtime_q[31:0]};
                REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
                REG_MTIMECMP_HI: mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    // mtimecmp resets to all-ones so no timer interrupt is pending out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        case (reg_sel)
            REG_MTIMECMP_LO: rdata_o = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: rdata_o = mtimecmp_q[63:32];
            REG_MTIME_LO:    rdata_o = mtime_q[31:0];
            REG_MTIME_HI:    rdata_o = mtime_q[63:32];
            default:         rdata_o = 32'd0;
        endcase
    end

    assign mtime_ge_mtimecmp_o = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/trap_timer_pipe_ctrl.sv
// trap_timer_pipe_ctrl
// Machine timer plus pipeline hazard controller for the 5-stage core.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   clint_*                       - timer register bus and compare flag
//   compress_stall .. trap_stall_valid_wb_i
//                                 - stall/flush requests from every stage
//   stall_o, flush_o              - per-register hold / bubble vectors,
//                                   bits 0..5 = PC, IF/ID, ID/EX, EX/MEM,
//                                   MEM/WB, WB
module trap_timer_pipe_ctrl
    import clint_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clint_addr_i,
    input  logic        clint_write_valid_i,
    input  logic [31:0] clint_wdata_i,
    output logic [31:0] clint_rdata_o,
    output logic        mtime_ge_mtimecmp_o,
    input  logic        compress_stall,
    input  logic        if_rdata_valid_i,
    input  logic        ram_stall_valid_if_i,
    input  logic        ls_valid_i,
    input  logic        arb_rdata_ready_i,
    input  logic        arb_wdata_ready_i,
    input  logic        ram_stall_valid_mem_i,
    input  logic        load_use_valid_id_i,
    input  logic        jump_valid_ex_i,
    input  logic        alu_mul_div_valid_ex_i,
    input  logic        trap_flush_valid_wb_i,
    input  logic        trap_stall_valid_wb_i,
    output logic [5:0]  stall_o,
    output logic [5:0]  flush_o
);

    logic mem_stall;
    logic if_stall;

    clint_mtime u_mtime (
        .clk                 (clk),
        .rst_n               (rst),
        .addr_i              (clint_addr_i),
        .write_valid_i       (clint_write_valid_i),
        .wdata_i             (clint_wdata_i),
        .rdata_o             (clint_rdata_o),
        .mtime_ge_mtimecmp_o (mtime_ge_mtimecmp_o)
    );

    // A load/store waits until either arbiter side acknowledges it.
    assign mem_stall = ram_stall_valid_mem_i |
                       (ls_valid_i & ~arb_rdata_ready_i & ~arb_wdata_ready_i);
    assign if_stall  = ram_stall_valid_if_i | ~if_rdata_valid_i | compress_stall;

    // Strict priority: the oldest stage / trap unit wins. Reset is checked
    // combinationally too so the pipeline is flushed for the whole reset.
    always_comb begin
        stall_o = STALL_NONE;
        flush_o = FLUSH_NONE;
        if (!rst) begin
            flush_o = FLUSH_RESET;
        end else if (trap_flush_valid_wb_i) begin
            flush_o = FLUSH_TRAP;
        end else if (trap_stall_valid_wb_i) begin
            stall_o = STALL_TRAP;
        end else if (mem_stall) begin
            stall_o = STALL_MEM;
            flush_o = FLUSH_MEM;
        end else if (alu_mul_div_valid_ex_i) begin
            stall_o = STALL_MULDIV;
            flush_o = FLUSH_MULDIV;
        end else if (jump_valid_ex_i) begin
            flush_o = FLUSH_JUMP;
        end else if (load_use_valid_id_i) begin
            stall_o = STALL_LOAD_USE;
            flush_o = FLUSH_LOAD_USE;
        end else if (if_stall) begin
            stall_o = STALL_IF;
            flush_o = FLUSH_IF;
        end
    end

endmodule

// File: tb/tb_trap_timer_pipe_ctrl.sv
// tb_trap_timer_pipe_ctrl
// Directed bench: stimulus pushes hand-computed expectations into a
// scoreboard queue; a monitor pops and compares them on each falling edge.
module tb_trap_timer_pipe_ctrl;

    typedef enum int {K_RDATA, K_GE, K_STALL, K_FLUSH} kind_e;

    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } sb_entry_t;

    // Control-input bit positions for applyStimulus
    localparam logic [11:0] C_COMPRESS = 12'h001;
    localparam logic [11:0] C_IFVALID  = 12'h002;
    localparam logic [11:0] C_RAMIF    = 12'h004;
    localparam logic [11:0] C_LS       = 12'h008;
    localparam logic [11:0] C_ARBR     = 12'h010;
    localparam logic [11:0] C_ARBW     = 12'h020;
    localparam logic [11:0] C_RAMMEM   = 12'h040;
    localparam logic [11:0] C_LOADUSE  = 12'h080;
    localparam logic [11:0] C_JUMP     = 12'h100;
    localparam logic [11:0] C_MULDIV   = 12'h200;
    localparam logic [11:0] C_TFLUSH   = 12'h400;
    localparam logic [11:0] C_TSTALL   = 12'h800;

    localparam logic [31:0] A_CMP_LO  = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI  = 32'h0200_4004;
    localparam logic [31:0] A_TIME_LO = 32'h0200_BFF8;
    localparam logic [31:0] A_TIME_HI = 32'h0200_BFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clint_addr_i = 32'd0;
    logic        clint_write_valid_i = 1'b0;
    logic [31:0] clint_wdata_i = 32'd0;
    logic [31:0] clint_rdata_o;
    logic        mtime_ge_mtimecmp_o;
    logic        compress_stall = 1'b0;
    logic        if_rdata_valid_i = 1'b1;
    logic        ram_stall_valid_if_i = 1'b0;
    logic        ls_valid_i = 1'b0;
    logic        arb_rdata_ready_i = 1'b0;
    logic        arb_wdata_ready_i = 1'b0;
    logic        ram_stall_valid_mem_i = 1'b0;
    logic        load_use_valid_id_i = 1'b0;
    logic        jump_valid_ex_i = 1'b0;
    logic        alu_mul_div_valid_ex_i = 1'b0;
    logic        trap_flush_valid_wb_i = 1'b0;
    logic        trap_stall_valid_wb_i = 1'b0;
    logic [5:0]  stall_o;
    logic [5:0]  flush_o;

    sb_entry_t sb[$];
    int checks = 0;
    int failures = 0;

    trap_timer_pipe_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .clint_addr_i           (clint_addr_i),
        .clint_write_valid_i    (clint_write_valid_i),
        .clint_wdata_i          (clint_wdata_i),
        .clint_rdata_o          (clint_rdata_o),
        .mtime_ge_mtimecmp_o    (mtime_ge_mtimecmp_o),
        .compress_stall         (compress_stall),
        .if_rdata_valid_i       (if_rdata_valid_i),
        .ram_stall_valid_if_i   (ram_stall_valid_if_i),
        .ls_valid_i             (ls_valid_i),
        .arb_rdata_ready_i      (arb_rdata_ready_i),
        .arb_wdata_ready_i      (arb_wdata_ready_i),
        .ram_stall_valid_mem_i  (ram_stall_valid_mem_i),
        .load_use_valid_id_i    (load_use_valid_id_i),
        .jump_valid_ex_i        (jump_valid_ex_i),
        .alu_mul_div_valid_ex_i (alu_mul_div_valid_ex_i),
        .trap_flush_valid_wb_i  (trap_flush_valid_wb_i),
        .trap_stall_valid_wb_i  (trap_stall_valid_wb_i),
        .stall_o                (stall_o),
        .flush_o                (flush_o)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation queued during a cycle is compared on the
    // falling edge, well away from the rising edge that updates the timer.
    always @(negedge clk) begin : monitor
        sb_entry_t   e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RDATA: act = clint_rdata_o;
                K_GE:    act = {31'd0, mtime_ge_mtimecmp_o};
                K_STALL: act = {26'd0, stall_o};
                default: act = {26'd0, flush_o};
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic checkOutput(input string name, input kind_e kind, input logic [31:0] exp);
        sb_entry_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic checkPipe(input string name, input logic [5:0] st, input logic [5:0] fl);
        checkOutput({name, "_stall"}, K_STALL, {26'd0, st});
        checkOutput({name, "_flush"}, K_FLUSH, {26'd0, fl});
    endtask

    // Read the addressed word this cycle (no write strobe)
    task automatic checkRead(input string name, input logic [31:0] addr, input logic [31:0] exp);
        clint_addr_i        = addr;
        clint_write_valid_i = 1'b0;
        checkOutput(name, K_RDATA, exp);
    endtask

    task automatic applyStimulus(input logic [11:0] c);
        compress_stall         = |(c & C_COMPRESS);
        if_rdata_valid_i       = |(c & C_IFVALID);
        ram_stall_valid_if_i   = |(c & C_RAMIF);
        ls_valid_i             = |(c & C_LS);
        arb_rdata_ready_i      = |(c & C_ARBR);
        arb_wdata_ready_i      = |(c & C_ARBW);
        ram_stall_valid_mem_i  = |(c & C_RAMMEM);
        load_use_valid_id_i    = |(c & C_LOADUSE);
        jump_valid_ex_i        = |(c & C_JUMP);
        alu_mul_div_valid_ex_i = |(c & C_MULDIV);
        trap_flush_valid_wb_i  = |(c & C_TFLUSH);
        trap_stall_valid_wb_i  = |(c & C_TSTALL);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        clint_addr_i        = addr;
        clint_wdata_i       = data;
        clint_write_valid_i = 1'b1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        applyStimulus(C_IFVALID);
        #1 rst = 1'b0;
        checkRead("reset_mtime_lo", A_TIME_LO, 32'd0);
        checkOutput("reset_ge", K_GE, 32'd0);
        checkPipe("reset", 6'b000000, 6'b111111);
        tick(2);
        rst = 1'b1;

        // mtime = 0 in the first cycle after release
        checkRead("post_reset_mtime", A_TIME_LO, 32'd0);
        checkOutput("post_reset_ge", K_GE, 32'd0);
        checkPipe("idle", 6'b000000, 6'b000000);
        tick(5);
        checkRead("mtime_after5", A_TIME_LO, 32'd5);
        tick(1);

        // mtime=6: write mtimecmp = 20
        busWrite(A_CMP_LO, 32'd20);
        tick(1);
        busWrite(A_CMP_HI, 32'd0);
        checkOutput("cmp_half_written_ge", K_GE, 32'd0);
        tick(1);
        checkRead("cmp_lo_read", A_CMP_LO, 32'd20);
        checkOutput("ge_at8", K_GE, 32'd0);
        tick(1);
        checkRead("cmp_hi_read", A_CMP_HI, 32'd0);
        tick(1);
        checkRead("mtime_10", A_TIME_LO, 32'd10);
        checkOutput("ge_at10", K_GE, 32'd0);
        tick(9);
        checkRead("mtime_19", A_TIME_LO, 32'd19);
        checkOutput("ge_at19", K_GE, 32'd0);
        tick(1);
        checkRead("mtime_20", A_TIME_LO, 32'd20);
        checkOutput("ge_at20", K_GE, 32'd1);
        tick(3);
        checkOutput("ge_at23", K_GE, 32'd1);
        tick(1);

        // Low-half overwrite: no increment in the write cycle
        busWrite(A_TIME_LO, 32'd0);
        tick(1);
        checkRead("mtime_overwritten", A_TIME_LO, 32'd0);
        checkOutput("ge_after_overwrite", K_GE, 32'd0);
        tick(1);
        checkRead("mtime_resumes", A_TIME_LO, 32'd1);
        tick(1);

        // Carry from low to high half
        busWrite(A_TIME_LO, 32'hFFFF_FFFF);
        tick(1);
        busWrite(A_TIME_HI, 32'd0);
        tick(1);
        checkRead("carry_lo_before", A_TIME_LO, 32'hFFFF_FFFF);
        checkOutput("carry_ge", K_GE, 32'd1);
        tick(1);
        checkRead("carry_hi", A_TIME_HI, 32'd1);
        tick(1);
        checkRead("carry_lo_after", A_TIME_LO, 32'd1);
        tick(1);

        // Unmapped address: reads zero, write ignored
        busWrite(32'h0200_0010, 32'h0000_DEAD);
        checkOutput("unmapped_read", K_RDATA, 32'd0);
        tick(1);
        checkRead("unmapped_mtime_lo", A_TIME_LO, 32'd3);
        tick(1);
        checkRead("unmapped_mtime_hi", A_TIME_HI, 32'd1);
        tick(1);
        checkRead("unmapped_cmp_lo", A_CMP_LO, 32'd20);
        tick(1);

        // Hazard priority
        applyStimulus(C_RAMIF | C_LOADUSE | C_JUMP | C_IFVALID);
        checkPipe("jump_over_lu_if", 6'b000000, 6'b000110);
        tick(1);
        applyStimulus(C_RAMIF | C_LOADUSE | C_JUMP | C_MULDIV | C_IFVALID);
        checkPipe("muldiv_wins", 6'b001111, 6'b010000);
        tick(1);
        applyStimulus(C_RAMIF | C_LOADUSE | C_JUMP | C_MULDIV | C_TFLUSH | C_IFVALID);
        checkPipe("trap_flush_wins", 6'b000000, 6'b011110);
        tick(1);
        applyStimulus(C_TFLUSH | C_TSTALL | C_LS | C_IFVALID);
        checkPipe("flush_over_stall", 6'b000000, 6'b011110);
        tick(1);
        applyStimulus(C_TSTALL | C_LS | C_MULDIV | C_IFVALID);
        checkPipe("trap_stall", 6'b111111, 6'b000000);
        tick(1);
        applyStimulus(C_LS | C_MULDIV | C_IFVALID);
        checkPipe("mem_wait", 6'b011111, 6'b100000);
        tick(1);
        applyStimulus(C_LS | C_ARBR | C_IFVALID);
        checkPipe("mem_rdata_ready", 6'b000000, 6'b000000);
        tick(1);
        applyStimulus(C_LS | C_ARBW | C_IFVALID);
        checkPipe("mem_wdata_ready", 6'b000000, 6'b000000);
        tick(1);
        applyStimulus(C_RAMMEM | C_ARBR | C_IFVALID);
        checkPipe("ram_mem_stall", 6'b011111, 6'b100000);
        tick(1);
        applyStimulus(C_LOADUSE | C_COMPRESS | C_IFVALID);
        checkPipe("load_use", 6'b000011, 6'b000100);
        tick(1);
        applyStimulus(C_COMPRESS | C_IFVALID);
        checkPipe("compress_stall", 6'b000001, 6'b000010);
        tick(1);
        applyStimulus(12'h000);
        checkPipe("fetch_not_valid", 6'b000001, 6'b000010);
        tick(1);
        applyStimulus(C_RAMIF | C_IFVALID);
        checkPipe("ram_if_stall", 6'b000001, 6'b000010);
        tick(1);

        // Asynchronous reset mid-operation
        applyStimulus(C_TSTALL | C_IFVALID);
        rst = 1'b0;
        checkRead("midreset_mtime_lo", A_TIME_LO, 32'd0);
        checkOutput("midreset_ge", K_GE, 32'd0);
        checkPipe("midreset", 6'b000000, 6'b111111);
        tick(1);
        checkRead("midreset_mtime_hi", A_TIME_HI, 32'd0);
        tick(1);
        checkRead("midreset_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
        tick(1);
        applyStimulus(C_IFVALID);
        rst = 1'b1;
        checkRead("release_mtime", A_TIME_LO, 32'd0);
        tick(1);
        checkRead("release_count", A_TIME_LO, 32'd1);
        tick(2);

        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
